instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 Port: mem_req  out  1  memory read request, held high until acknowledged.
REQ-005 Port: mem_addr  out  16  read address, stable while mem_req high.
REQ-006 Port: mem_ack  in  1  read acknowledge; mem_rdata valid in the same cycle.
REQ-007 Port: mem_rdata  in  16  read data.
REQ-008 Port: rf_rd_addr  out  3  register-file read address (combinational read port).
REQ-009 Port: rf_rd_data  in  16  register-file read data.
REQ-010 Port: rf_wr_en  out  1  register-file write strobe, one cycle per write.
REQ-011 Port: rf_wr_addr  out  3  register-file write address.
REQ-012 Port: rf_wr_data  out  16  register-file write data.
REQ-013 Port: pc  out  16  current program counter.
REQ-014 Port: instr_done  out  1  one-cycle pulse at instruction retirement.
REQ-015 Port: halted  out  1  high while in HALT.

Function
REQ-016 Instruction word: [15:12] opcode, [11:9] op1 register, [8:6] op2 register, [5:0] ignored.
REQ-017 Opcodes:
- 4'b1011 MOV: R[op1] <- R[op2].
- 4'b1100 MVI: R[op1] <- next word.
- 4'b1101 LDA: R0 <- mem[next word].
- 4'b1111 HLT.
- All others NOP.
REQ-018 FSM states: FETCH, DECODE, IMM, MEMRD, WB, HALT; mem_req, mem_addr, rf_wr_* and halted are functions of state and internal registers only (Moore).
REQ-019 FETCH: mem_req=1, mem_addr=pc; on mem_ack, IR <= mem_rdata, pc <= pc+1, go to DECODE; without ack, remain.
REQ-020 DECODE transitions:
- MOV: rf_rd_addr=IR[8:6], latch rf_rd_data into WDATA, go to WB.
- MVI or LDA: go to IMM.
- HLT: go to HALT.
- NOP: pulse instr_done, go to FETCH.
REQ-021 IMM: mem_req=1, mem_addr=pc; on mem_ack, pc <= pc+1.
- MVI: WDATA <= mem_rdata, go to WB.
- LDA: OPADDR <= mem_rdata, go to MEMRD.
REQ-022 MEMRD: mem_req=1, mem_addr=OPADDR; on mem_ack, WDATA <= mem_rdata, go to WB.
REQ-023 WB: rf_wr_en=1, rf_wr_data=WDATA, rf_wr_addr=IR[11:9] (MOV/MVI) or 3'b000 (LDA); instr_done=1; go to FETCH.
REQ-024 HALT: no requests, no writes, halted=1; exit only via reset.
REQ-025 mem_ack while mem_req is low is ignored.
REQ-026 pc increments modulo 2^16 (16'hFFFF -> 16'h0000); an immediate word fetched at 16'hFFFF wraps to 0 for the following fetch.
REQ-027 Zero-wait latency (ack in the request cycle), fetch to next fetch: NOP 2, MOV 3, MVI 4, LDA 5 cycles; each ack wait state adds one cycle.
REQ-028 rf_rd_addr = IR[8:6] in all states; it is only sampled in DECODE.

Reset
REQ-029 rst_n low at a rising edge forces: state FETCH, pc=RESET_PC, IR/WDATA/OPADDR=0, rf_wr_en=0, instr_done=0, halted=0.
REQ-030 In the cycle after reset release, mem_req=1 with mem_addr=RESET_PC.
REQ-031 Reset mid-instruction abandons it: no register write, no pc increment; a mem_ack coincident with rst_n low is ignored.

Verification
REQ-032 MOV: mem[0]=16'hB4C0 (R2<-R3), R3=16'h1234, zero-wait -> rf write addr 2, data 16'h1234 on cycle 3; pc=1.
REQ-033 MVI: mem[0]=16'hC200, mem[1]=16'hBEEF -> rf write addr 1, data 16'hBEEF on cycle 4; pc=2.
REQ-034 LDA with waits: mem[0]=16'hD000, mem[1]=16'h0040, mem[16'h40]=16'hA5A5, 2-cycle ack delay per access -> MEMRD mem_addr=16'h0040; rf write addr 0, data 16'hA5A5; total 11 cycles.
REQ-035 Wrap: RESET_PC=16'hFFFF, mem[FFFF]=MVI, mem[0]=16'h0007 -> immediate read at 16'h0000, pc=16'h0001 after write.
REQ-036 HLT (16'hF000): halted=1 and mem_req=0 for 20+ cycles; rst_n low one edge -> fetch resumes at RESET_PC.
REQ-037 Reset during MEMRD wait: no rf_wr_en pulse; next cycle after release, mem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer for MOV/MVI/LDA/HLT/NOP over a single-port ack-based read bus and a 1R1W register file.
// Latency: NOP 2, MOV 3, MVI 4, LDA 5 cycles fetch-to-fetch; each bus wait state adds one cycle.
// Backpressure: every bus access holds mem_req/mem_addr steady until mem_ack; HALT leaves only via reset.
module instr_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [2:0]  rf_rd_addr,
    input  logic [15:0] rf_rd_data,
    output logic        rf_wr_en,
    output logic [2:0]  rf_wr_addr,
    output logic [15:0] rf_wr_data,
    output logic [15:0] pc,
    output logic        instr_done,
    output logic        halted
);

    localparam logic [3:0] OP_MOV = 4'b1011;
    localparam logic [3:0] OP_MVI = 4'b1100;
    localparam logic [3:0] OP_LDA = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_IMM,
        S_MEMRD,
        S_WB,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    // Operand bits [5:0] carry no meaning, so only the decoded fields are held.
    logic [15:6] ir_q, ir_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] opaddr_q, opaddr_d;
    logic [3:0]  opcode;

    assign opcode     = ir_q[15:12];
    assign rf_rd_addr = ir_q[8:6];
    assign rf_wr_addr = (opcode == OP_LDA) ? 3'b000 : ir_q[11:9];
    assign rf_wr_data = wdata_q;
    assign pc         = pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        wdata_d    = wdata_q;
        opaddr_d   = opaddr_q;
        mem_req    = 1'b0;
        mem_addr   = pc_q;
        rf_wr_en   = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_d    = mem_rdata[15:6];
                    pc_d    = pc_q + 16'd1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_MOV: begin
                        wdata_d = rf_rd_data;
                        state_d = S_WB;
                    end
                    OP_MVI, OP_LDA: state_d = S_IMM;
                    OP_HLT:         state_d = S_HALT;
                    default: begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_IMM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_d = pc_q + 16'd1;
                    if (opcode == OP_LDA) begin
                        opaddr_d = mem_rdata;
                        state_d  = S_MEMRD;
                    end else begin
                        wdata_d = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_MEMRD: begin
                mem_req  = 1'b1;
                mem_addr = opaddr_q;
                if (mem_ack) begin
                    wdata_d = mem_rdata;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rf_wr_en   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            wdata_q  <= '0;
            opaddr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            wdata_q  <= wdata_d;
            opaddr_q <= opaddr_d;
        end
    end

endmodule
